line_clear_ctrl: RTL and testbench

LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

---
 rtl/game_pkg.sv | 27 ++
 rtl/row_full_detect.sv | 16 +
 rtl/line_clear_ctrl.sv | 118 +++++++++++
 tb/tb_line_clear_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared board geometry, row types and line-clear FSM states
package game_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int CELL_W  = 3;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t [BOARD_W-1:0] row_t;

  typedef enum logic [1:0] {
    LCC_IDLE = 2'd0,
    LCC_SCAN = 2'd1,
    LCC_FILL = 2'd2,
    LCC_DONE = 2'd3
  } lcc_state_t;

  // Square is formed at 10 bits (20*20 = 400) so only the final add needs saturation.
  function automatic logic [15:0] score_sat_add(input logic [15:0] score, input logic [4:0] lines);
    logic [9:0]  sq;
    logic [16:0] sum;
    sq  = 10'(lines) * 10'(lines);
    sum = {1'b0, score} + {7'd0, sq};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// rtl/row_full_detect.sv - flags a board row whose every cell holds a nonzero colour
module row_full_detect
  import game_pkg::*;
(
  input  row_t i_row,
  output logic o_full
);

  always_comb begin
    o_full = 1'b1;
    for (int c = 0; c < BOARD_W; c++) begin
      if (i_row[c] == '0) o_full = 1'b0;
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// rtl/line_clear_ctrl.sv - compacts the board bottom-up after a lock, removing full rows and scoring
module line_clear_ctrl
  import game_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [4:0]  o_rd_row,
  input  logic [29:0] i_rd_data,
  output logic        o_wr_en,
  output logic [4:0]  o_wr_row,
  output logic [29:0] o_wr_data,
  output logic [4:0]  o_lines,
  output logic [15:0] o_score
);

  localparam logic [4:0] LAST_ROW = 5'(BOARD_H - 1);

  lcc_state_t  state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wr_q, wr_d;
  logic [4:0]  lines_q, lines_d;
  logic [4:0]  lines_out_q, lines_out_d;
  logic [15:0] score_q, score_d;
  logic [15:0] score_new;
  logic        row_full;
  row_t        rd_row;

  assign rd_row = i_rd_data;

  row_full_detect u_row_full_detect (
    .i_row  (rd_row),
    .o_full (row_full)
  );

  assign score_new = score_sat_add(score_q, lines_q);

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    lines_d     = lines_q;
    lines_out_d = lines_out_q;
    score_d     = score_q;
    o_rd_row    = '0;
    o_wr_en     = 1'b0;
    o_wr_row    = '0;
    o_wr_data   = '0;
    unique case (state_q)
      LCC_IDLE: begin
        if (i_start) begin
          rd_d    = LAST_ROW;
          wr_d    = LAST_ROW;
          lines_d = '0;
          state_d = LCC_SCAN;
        end
      end
      LCC_SCAN: begin
        o_rd_row = rd_q;
        if (row_full) begin
          lines_d = lines_q + 5'd1;
        end else begin
          // wr trails rd, so a write only ever lands on a row already consumed
          if (wr_q != rd_q) begin
            o_wr_en   = 1'b1;
            o_wr_row  = wr_q;
            o_wr_data = i_rd_data;
          end
          if (wr_q != '0) wr_d = wr_q - 5'd1;
        end
        if (rd_q == '0) begin
          state_d = (lines_d != '0) ? LCC_FILL : LCC_DONE;
        end else begin
          rd_d = rd_q - 5'd1;
        end
      end
      LCC_FILL: begin
        o_wr_en  = 1'b1;
        o_wr_row = wr_q;
        if (wr_q == '0) state_d = LCC_DONE;
        else            wr_d    = wr_q - 5'd1;
      end
      LCC_DONE: begin
        lines_out_d = lines_q;
        score_d     = score_new;
        state_d     = LCC_IDLE;
      end
      default: state_d = LCC_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= LCC_IDLE;
      rd_q        <= '0;
      wr_q        <= '0;
      lines_q     <= '0;
      lines_out_q <= '0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      lines_q     <= lines_d;
      lines_out_q <= lines_out_d;
      score_q     <= score_d;
    end
  end

  // The DONE cycle already presents this pass's result; the registers catch up on exit.
  assign o_busy  = (state_q != LCC_IDLE);
  assign o_done  = (state_q == LCC_DONE);
  assign o_lines = (state_q == LCC_DONE) ? lines_q : lines_out_q;
  assign o_score = (state_q == LCC_DONE) ? score_new : score_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb/tb_line_clear_ctrl.sv - scoreboard bench for line_clear_ctrl against a board-level model
module tb_line_clear_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, wr_en;
  logic [4:0]  rd_row, wr_row, lines;
  logic [29:0] rd_data, wr_data;
  logic [15:0] score;

  always #5 clk = ~clk;

  line_clear_ctrl dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .o_busy    (busy),
    .o_done    (done),
    .o_rd_row  (rd_row),
    .i_rd_data (rd_data),
    .o_wr_en   (wr_en),
    .o_wr_row  (wr_row),
    .o_wr_data (wr_data),
    .o_lines   (lines),
    .o_score   (score)
  );

  logic [29:0] board    [20];
  logic [29:0] load_img [20];
  logic        load_en = 1'b0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int r = 0; r < 20; r++) board[r] <= load_img[r];
    end else if (wr_en && wr_row < 5'd20) begin
      board[wr_row] <= wr_data;
    end
  end

  always_comb rd_data = (rd_row < 5'd20) ? board[rd_row] : 30'd0;

  typedef struct { logic [4:0] row; logic [29:0] data; } wr_t;
  typedef struct { int lines; int score; int lat; } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  logic [29:0] exp_board [20];

  int tests = 0;
  int fails = 0;
  int score_m = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic bit row_is_full(input logic [29:0] r);
    for (int c = 0; c < 10; c++) begin
      if (r[3*c +: 3] == 3'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Surviving rows keep their order and sink to the bottom; the k-th survivor from the bottom lands on row 19-k.
  task automatic predict();
    int n_full = 0;
    int rank = 0;
    logic [29:0] kept[$];
    for (int r = 19; r >= 0; r--) begin
      if (row_is_full(board[r])) begin
        n_full++;
      end else begin
        if (19 - rank != r) exp_wr.push_back('{5'(19 - rank), board[r]});
        kept.push_back(board[r]);
        rank++;
      end
    end
    for (int r = n_full - 1; r >= 0; r--) exp_wr.push_back('{5'(r), 30'd0});
    for (int r = 0; r < 20; r++) exp_board[r] = (19 - r < kept.size()) ? kept[19 - r] : 30'd0;
    score_m = (score_m + n_full * n_full > 65535) ? 65535 : score_m + n_full * n_full;
    exp_done.push_back('{n_full, score_m, 21 + n_full});
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt = busy_cnt + 1;
    else      busy_cnt = 0;
    if (wr_en) begin
      if (!busy) fail_now("wr_while_idle");
      if (exp_wr.size() == 0) begin
        fail_now("wr_unexpected");
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_row", wr_row, w.row);
        check("wr_data", wr_data, w.data);
      end
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      if (exp_done.size() == 0) begin
        fail_now("done_unexpected");
      end else begin
        done_t d;
        d = exp_done.pop_front();
        check("lines", lines, d.lines);
        check("score", score, d.score);
        check("latency", busy_cnt, d.lat);
        check("wr_missing", exp_wr.size(), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_board();
    tick();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (exp_done.size() == 0) break;
      tick();
    end
    if (exp_done.size() != 0) begin
      fail_now("done_timeout");
      exp_done.delete();
      exp_wr.delete();
    end
    tick();
  endtask

  task automatic run_pass(input bit check_board);
    predict();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    if (check_board) begin
      for (int r = 0; r < 20; r++) check("board_row", board[r], exp_board[r]);
    end
  endtask

  function automatic logic [29:0] full_row();
    logic [29:0] v;
    for (int c = 0; c < 10; c++) v[3*c +: 3] = 3'($urandom_range(1, 7));
    return v;
  endfunction

  task automatic img_fill(input int first_full, input logic [29:0] other);
    for (int r = 0; r < 20; r++) load_img[r] = (r >= first_full) ? full_row() : other;
  endtask

  task automatic img_random();
    for (int r = 0; r < 20; r++) begin
      logic [29:0] v;
      case ($urandom_range(0, 3))
        0:       v = 30'd0;
        1:       v = full_row();
        default: begin
          for (int c = 0; c < 10; c++) v[3*c +: 3] = 3'($urandom_range(0, 7));
          v[3*$urandom_range(0, 9) +: 3] = 3'd0;
        end
      endcase
      load_img[r] = v;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: run exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_row", rd_row, 0);
    check("rst_wr_row", wr_row, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_lines", lines, 0);
    check("rst_score", score, 0);
    rst_n = 1'b1;
    tick();

    img_fill(20, 30'd0);
    load_board();
    run_pass(1'b1);

    img_fill(19, 30'd0);
    load_board();
    run_pass(1'b1);

    img_fill(16, 30'd0);
    load_img[15] = 30'd1;
    load_board();
    run_pass(1'b1);

    for (int t = 0; t < 25; t++) begin
      img_random();
      load_board();
      run_pass(1'b1);
    end

    begin
      int d0;
      img_random();
      load_img[19] = full_row();
      load_board();
      d0 = done_cnt;
      predict();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();
      repeat (30) tick();
      check("done_count", done_cnt - d0, 1);
    end

    img_fill(19, 30'd0);
    load_board();
    predict();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    exp_wr.delete();
    exp_done.delete();
    score_m = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_score", score, 0);
    tick();
    check("abort_busy_edge", busy, 0);
    check("abort_done_edge", done, 0);
    rst_n = 1'b1;
    tick();
    img_random();
    load_board();
    run_pass(1'b1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    score_m = 0;
    tick();
    for (int p = 0; p < 163; p++) begin
      img_fill(0, 30'd0);
      load_board();
      run_pass(1'b0);
    end
    for (int p = 0; p < 20; p++) begin
      img_fill(16, 30'd0);
      load_board();
      run_pass(1'b0);
    end
    check("score_pre_sat", score, 16'hFFF0);
    img_fill(16, 30'd0);
    load_board();
    run_pass(1'b1);
    check("score_sat", score, 16'hFFFF);
    img_fill(18, 30'd0);
    load_board();
    run_pass(1'b1);
    check("score_sat_hold", score, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
